// File: rtl/successive_approximation_controller.sv
// SAR search engine: drives a trial code into an external magnitude comparator and resolves the unknown MSB first.
// Optional build macro SAR_EARLY_EXIT_EN: a valid Equal flag in EVAL finishes the conversion immediately.
module successive_approximation_controller #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic                  A_Less_Than_B_In,
    input  logic                  A_Equal_To_B_In,
    input  logic                  A_Greater_Than_B_In,
    output logic [DATA_WIDTH-1:0] Compare_Code_Out,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic                  Flag_Error_Out
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      IDX_MSB   = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] CODE_ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CODE_INIT = CODE_ONE << (DATA_WIDTH - 1);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 16) begin : g_bad_width
        $error("successive_approximation_controller: DATA_WIDTH must be 2..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] code_q, code_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [2:0]            flags_c;
    logic                  flags_valid_c;
    logic                  early_exit_c;
    logic [DATA_WIDTH-1:0] resolved_c;

    // Comparator flags are only trusted when exactly one is asserted.
    always_comb begin
        flags_c       = {A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In};
        flags_valid_c = (flags_c == 3'b100) || (flags_c == 3'b010) || (flags_c == 3'b001);
`ifdef SAR_EARLY_EXIT_EN
        early_exit_c  = A_Equal_To_B_In;
`else
        early_exit_c  = 1'b0;
`endif
        resolved_c    = code_q;
        if (A_Greater_Than_B_In) begin
            resolved_c = code_q & ~(CODE_ONE << idx_q);
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (Start_In) begin
                    code_d  = CODE_INIT;
                    idx_d   = IDX_MSB;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                if (!flags_valid_c) begin
                    // Comparator absent, in reset or contradictory: abort with a zero result.
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (early_exit_c || (idx_q == '0)) begin
                    result_d = resolved_c;
                    code_d   = resolved_c;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    code_d  = resolved_c | (CODE_ONE << (idx_q - IDX_W'(1)));
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = ST_SETTLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Compare_Code_Out = code_q;
    assign Result_Out       = result_q;
    assign Busy_Out         = busy_q;
    assign Done_Out         = done_q;
    assign Flag_Error_Out   = err_q;

endmodule

// File: tb/tb_successive_approximation_controller.sv
// Bench for successive_approximation_controller (W=8): comparator model plus a result scoreboard.
module tb_successive_approximation_controller;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         lt, eq, gt;
    logic [W-1:0] code, result;
    logic         busy, done, err;

    logic [W-1:0] target;
    logic         force_zero;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int unsigned  acc_edge;
        int unsigned  lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned edge_cnt;
    int unsigned total;
    int unsigned bad;
    logic        done_prev;

    successive_approximation_controller #(.DATA_WIDTH(W)) dut (
        .Clock_In            (clk),
        .Reset_In            (rst),
        .Start_In            (start),
        .A_Less_Than_B_In    (lt),
        .A_Equal_To_B_In     (eq),
        .A_Greater_Than_B_In (gt),
        .Compare_Code_Out    (code),
        .Result_Out          (result),
        .Busy_Out            (busy),
        .Done_Out            (done),
        .Flag_Error_Out      (err)
    );

    // External comparator: A = trial code, B = target; force_zero models a dead comparator.
    assign lt = force_zero ? 1'b0 : (code <  target);
    assign eq = force_zero ? 1'b0 : (code == target);
    assign gt = force_zero ? 1'b0 : (code >  target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned exp_lat(input logic [W-1:0] t);
`ifdef SAR_EARLY_EXIT_EN
        for (int k = 0; k < W; k++) begin
            if (t[k]) return 2 * (W - k);
        end
        return 2 * W;
`else
        return 2 * W;
`endif
    endfunction

    // Called at a falling edge; the next rising edge accepts the Start.
    task automatic start_conv(input logic [W-1:0] tgt, input logic bad_flags);
        exp_t e;
        target     = tgt;
        force_zero = bad_flags;
        start      = 1'b1;
        e.res      = bad_flags ? '0 : tgt;
        e.err      = bad_flags;
        e.acc_edge = edge_cnt + 1;
        e.lat      = bad_flags ? 2 : exp_lat(tgt);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("err_cleared", err, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) check_val("done_timeout", done, 1);
    endtask

    // Scoreboard: every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check_val("done_width", done_prev, 0);
            if (sb_q.size() == 0) begin
                check_val("spurious_done", done, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("result", result, mon_e.res);
                check_val("flag_error", err, mon_e.err);
                check_val("latency", edge_cnt - mon_e.acc_edge, mon_e.lat);
                check_val("busy_at_done", busy, 0);
            end
        end
        done_prev = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] seq [8];
        int unsigned  a;
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        total = 0; bad = 0; edge_cnt = 0; done_prev = 1'b0;
        rst = 1'b1; start = 1'b0; target = '0; force_zero = 1'b0;

        #3;
        check_val("rst_code", code, 0);
        check_val("rst_result", result, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Trial-code walk for 0xA5
        start_conv(8'hA5, 1'b0);
        check_val("code_seq0", code, seq[0]);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("code_seq%0d", k), code, seq[k]);
        end
        wait_done();
        @(negedge clk);
        check_val("code_hold_idle", code, 8'hA5);

        start_conv(8'h00, 1'b0);
        wait_done();
        @(negedge clk);
        start_conv(8'hFF, 1'b0);
        wait_done();
        @(negedge clk);
        start_conv(8'h80, 1'b0);
        wait_done();
        @(negedge clk);

        // Start re-pulsed while busy is ignored; Start in the Done cycle is accepted
        start_conv(8'h3C, 1'b0);
        a = edge_cnt;
        while (edge_cnt < a + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start_conv(8'h11, 1'b0);
        wait_done();
        @(negedge clk);

        // Asynchronous reset mid-conversion
        start_conv(8'h77, 1'b0);
        a = edge_cnt;
        while (edge_cnt < a + 7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_code", code, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_result", result, 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        start_conv(8'h5A, 1'b0);
        wait_done();
        @(negedge clk);

        // Dead comparator aborts at the first EVAL; next Start clears the error
        start_conv(8'h33, 1'b1);
        wait_done();
        @(negedge clk);
        check_val("err_sticky", err, 1);
        start_conv(8'h33, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
